dac_drive: RTL

DAC_DRIVE -- requirements
Module: dac_drive

---
 rtl/awg_pkg.sv | 17 +
 rtl/dac_clk_div.sv | 33 +++
 rtl/dac_drive.sv | 119 +++++++++++
 3 files changed

// File: rtl/awg_pkg.sv
// Shared types and constants for the waveform generator output stages.
package awg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FADE = 2'd2
    } state_e;

    localparam int FADE_STEP_DEFAULT = 64;

    // Offset-binary zero code for a converter of the given width.
    function automatic int midscale(input int dw);
        return 1 << (dw - 1);
    endfunction

endpackage

// File: rtl/dac_clk_div.sv
// DAC sample-period counter: boundary pulse on the last count and a registered,
// glitch-free dac_clk that is low for the first half of the period.
module dac_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    output logic boundary,
    output logic dac_clk
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    // Flagging the last count lets registered updates land together with count 0.
    always_comb begin
        boundary = (cnt == CW'(DIV - 1));
        cnt_nxt  = boundary ? '0 : cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            dac_clk <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            dac_clk <= (cnt_nxt >= CW'(DIV / 2));
        end
    end

endmodule

// File: rtl/dac_drive.sv
// DAC output stage: one-entry sample hold, amplitude scaling, underrun flag and
// a fade-to-midscale on disable. dac_data only moves as a new period starts.
module dac_drive
    import awg_pkg::*;
#(
    parameter int DW        = 14,
    parameter int DIV       = 4,
    parameter int FADE_STEP = FADE_STEP_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [DW-1:0] sample_in,
    input  logic          sample_valid,
    output logic          sample_ready,
    input  logic [2:0]    state_amp,
    output logic [DW-1:0] dac_data,
    output logic          dac_clk,
    output logic          underrun,
    output logic          muted,
    output state_e        state_dbg
);

    localparam logic [DW-1:0] MID  = DW'(midscale(DW));
    localparam logic [DW:0]   STEP = (DW + 1)'(FADE_STEP);

    // Handshake: a sample transfers on a rising edge where sample_valid and
    // sample_ready are both high; sample_ready depends only on registered state.

    state_e          state;
    logic            hold_full;
    logic [DW-1:0]   hold_data;
    logic            boundary;
    logic            transfer;
    logic signed [DW:0] off;
    logic [DW:0]     mag;
    logic            fade_near;
    logic [DW-1:0]   fade_nxt;

    dac_clk_div #(.DIV(DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .boundary (boundary),
        .dac_clk  (dac_clk)
    );

    function automatic logic [DW-1:0] scale(input logic [DW-1:0] s, input logic [2:0] amp);
        logic signed [DW:0]   d;
        logic signed [4:0]    g;
        logic signed [DW+5:0] p;
        d = $signed({1'b0, s}) - $signed({1'b0, MID});
        g = $signed({2'b00, amp}) + 5'sd1;
        p = (DW + 6)'(d) * (DW + 6)'(g);
        p = (p >>> 3) + $signed((DW + 6)'(MID));
        return p[DW-1:0];
    endfunction

    assign sample_ready = (state == ST_RUN) && !hold_full;
    assign transfer     = sample_valid && sample_ready;
    assign muted        = (state == ST_IDLE);
    assign state_dbg    = state;

    always_comb begin
        off       = $signed({1'b0, dac_data}) - $signed({1'b0, MID});
        mag       = off[DW] ? $unsigned(-off) : $unsigned(off);
        fade_near = (mag <= STEP);
        fade_nxt  = off[DW] ? dac_data + DW'(FADE_STEP) : dac_data - DW'(FADE_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dac_data  <= MID;
            hold_full <= 1'b0;
            hold_data <= '0;
            underrun  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    dac_data <= MID;
                    if (en) begin
                        state    <= ST_RUN;
                        underrun <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (boundary) begin
                        if (hold_full) dac_data <= scale(hold_data, state_amp);
                        else           underrun <= 1'b1;
                    end
                    // The boundary above consumed the old hold contents first.
                    if (!en) begin
                        state     <= ST_FADE;
                        hold_full <= 1'b0;
                    end else if (transfer) begin
                        hold_data <= sample_in;
                        hold_full <= 1'b1;
                    end else if (boundary && hold_full) begin
                        hold_full <= 1'b0;
                    end
                end
                ST_FADE: begin
                    if (en) begin
                        state <= ST_RUN;
                    end else if (boundary) begin
                        if (fade_near) begin
                            dac_data <= MID;
                            state    <= ST_IDLE;
                        end else begin
                            dac_data <= fade_nxt;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
